pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RV32IM pipeline. It watches the ID-stage source registers, the instruction in EX, branch resolution and the multi-cycle multiply/divide unit (MDU). It drives write-enable and flush controls for the PC, IF/ID and ID/EX registers, and bubble control for EX/MEM. It sequences load-use stalls, taken-branch flushes and MDU busy holds, and counts stall cycles for performance monitoring.

---
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// squashes and multi-cycle MDU holds, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic [4:0]  EX_RD,
  input  logic        EX_MEM_READ,
  input  logic        EX_IS_MDU,
  input  logic        EX_BRANCH_TAKEN,
  input  logic        MDU_DONE,
  output logic        PC_WRITE,
  output logic        IF_ID_WRITE,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_WRITE,
  output logic        ID_EX_FLUSH,
  output logic        EX_MEM_BUBBLE,
  output logic        MDU_START,
  output logic        MDU_TIMEOUT,
  output logic [31:0] STALL_CYCLES
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   stall_reg;
  logic          load_use;

  assign load_use = EX_MEM_READ && (EX_RD != 5'd0) &&
                    ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                     (ID_USES_RS2 && (ID_RS2 == EX_RD)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      stall_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (!PC_WRITE && (stall_reg != 32'hFFFF_FFFF))
        stall_reg <= stall_reg + 32'd1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    PC_WRITE      = 1'b1;
    IF_ID_WRITE   = 1'b1;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_WRITE   = 1'b1;
    ID_EX_FLUSH   = 1'b0;
    EX_MEM_BUBBLE = 1'b0;
    MDU_START     = 1'b0;
    MDU_TIMEOUT   = 1'b0;

    case (state_reg)
      RUN: begin
        if (EX_BRANCH_TAKEN) begin
          IF_ID_FLUSH = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end else if (EX_IS_MDU) begin
          MDU_START     = 1'b1;
          PC_WRITE      = 1'b0;
          IF_ID_WRITE   = 1'b0;
          ID_EX_WRITE   = 1'b0;
          EX_MEM_BUBBLE = 1'b1;
          state_next    = MDU_BUSY;
          cnt_next      = '0;
        end else if (load_use) begin
          PC_WRITE    = 1'b0;
          IF_ID_WRITE = 1'b0;
          ID_EX_FLUSH = 1'b1;
        end
      end

      MDU_BUSY: begin
        // Done wins over the timeout check when both land on the same cycle.
        if (MDU_DONE) begin
          state_next = RUN;
        end else begin
          PC_WRITE      = 1'b0;
          IF_ID_WRITE   = 1'b0;
          ID_EX_WRITE   = 1'b0;
          EX_MEM_BUBBLE = 1'b1;
          cnt_next      = cnt_reg + CW'(1);
          if (cnt_reg == CW'(TIMEOUT - 1))
            state_next = ERROR;
        end
      end

      ERROR: begin
        PC_WRITE      = 1'b0;
        IF_ID_WRITE   = 1'b0;
        ID_EX_WRITE   = 1'b0;
        EX_MEM_BUBBLE = 1'b1;
        MDU_TIMEOUT   = 1'b1;
      end

      default: begin
        state_next = RUN;
      end
    endcase

    // While in reset the pipeline sees plain RUN defaults and no MDU start.
    if (RST) begin
      PC_WRITE      = 1'b1;
      IF_ID_WRITE   = 1'b1;
      IF_ID_FLUSH   = 1'b0;
      ID_EX_WRITE   = 1'b1;
      ID_EX_FLUSH   = 1'b0;
      EX_MEM_BUBBLE = 1'b0;
      MDU_START     = 1'b0;
      MDU_TIMEOUT   = 1'b0;
    end
  end

  assign STALL_CYCLES = stall_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: load-use, branch priority, MDU
// hold/release, timeout boundary and reset recovery.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  ID_RS1, ID_RS2, EX_RD;
  logic        ID_USES_RS1, ID_USES_RS2;
  logic        EX_MEM_READ, EX_IS_MDU, EX_BRANCH_TAKEN, MDU_DONE;
  logic        PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_WRITE, ID_EX_FLUSH;
  logic        EX_MEM_BUBBLE, MDU_START, MDU_TIMEOUT;
  logic [31:0] STALL_CYCLES;

  int checks   = 0;
  int failures = 0;
  int start_cnt = 0;
  logic [31:0] exp_stall;

  // {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_WRITE, ID_EX_FLUSH, EX_MEM_BUBBLE, MDU_START, MDU_TIMEOUT}
  localparam logic [7:0] C_RUN    = 8'b1101_0000;
  localparam logic [7:0] C_LDUSE  = 8'b0001_1000;
  localparam logic [7:0] C_BRANCH = 8'b1111_1000;
  localparam logic [7:0] C_ISSUE  = 8'b0000_0110;
  localparam logic [7:0] C_HOLD   = 8'b0000_0100;
  localparam logic [7:0] C_ERROR  = 8'b0000_0101;

  logic [7:0] ctl;
  assign ctl = {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_WRITE, ID_EX_FLUSH,
                EX_MEM_BUBBLE, MDU_START, MDU_TIMEOUT};

  pipeline_hazard_ctrl #(.TIMEOUT(40)) dut (
    .CLK(CLK), .RST(RST),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ), .EX_IS_MDU(EX_IS_MDU),
    .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .MDU_DONE(MDU_DONE),
    .PC_WRITE(PC_WRITE), .IF_ID_WRITE(IF_ID_WRITE), .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_WRITE(ID_EX_WRITE), .ID_EX_FLUSH(ID_EX_FLUSH),
    .EX_MEM_BUBBLE(EX_MEM_BUBBLE), .MDU_START(MDU_START),
    .MDU_TIMEOUT(MDU_TIMEOUT), .STALL_CYCLES(STALL_CYCLES)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (MDU_START && !RST) start_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=0x%0h", tag, got);
    end
  endtask

  task automatic idle();
    ID_RS1 = 5'd1; ID_RS2 = 5'd2; EX_RD = 5'd5;
    ID_USES_RS1 = 1'b0; ID_USES_RS2 = 1'b0;
    EX_MEM_READ = 1'b0; EX_IS_MDU = 1'b0; EX_BRANCH_TAKEN = 1'b0; MDU_DONE = 1'b0;
  endtask

  // Advance to the next negedge, then let combinational outputs settle after inputs change.
  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  // Issue an MDU op and hold it for 'busy' cycles without MDU_DONE, checking each.
  task automatic mdu_issue_and_hold(input int busy, input string tag);
    next_cycle(); idle(); EX_IS_MDU = 1'b1; settle();
    check({tag, "_issue"}, {24'd0, ctl}, {24'd0, C_ISSUE});
    for (int i = 0; i < busy; i++) begin
      next_cycle(); idle(); settle();
      check($sformatf("%s_hold%0d", tag, i + 1), {24'd0, ctl}, {24'd0, C_HOLD});
    end
  endtask

  initial begin
    idle();
    RST = 1'b1;
    exp_stall = 32'd0;

    // Reset: RUN defaults even with an MDU op presented
    next_cycle(); settle();
    check("rst_ctl", {24'd0, ctl}, {24'd0, C_RUN});
    check("rst_stall", STALL_CYCLES, 32'd0);
    EX_IS_MDU = 1'b1; settle();
    check("rst_mdu_no_start", {24'd0, ctl}, {24'd0, C_RUN});
    next_cycle(); idle(); RST = 1'b0; settle();
    check("rst_stall_after", STALL_CYCLES, 32'd0);

    // Load-use on RS2
    next_cycle(); idle(); EX_MEM_READ = 1'b1; EX_RD = 5'd5; ID_RS2 = 5'd5; ID_USES_RS2 = 1'b1; settle();
    check("lu_rs2", {24'd0, ctl}, {24'd0, C_LDUSE});
    next_cycle(); idle(); settle();
    exp_stall = 32'd1;
    check("lu_rs2_release", {24'd0, ctl}, {24'd0, C_RUN});
    check("lu_rs2_stall", STALL_CYCLES, exp_stall);

    // x0 destination never stalls
    EX_MEM_READ = 1'b1; EX_RD = 5'd0; ID_RS2 = 5'd0; ID_USES_RS2 = 1'b1; settle();
    check("lu_rd0", {24'd0, ctl}, {24'd0, C_RUN});
    // Unused source never stalls
    EX_RD = 5'd5; ID_RS2 = 5'd5; ID_USES_RS2 = 1'b0; settle();
    check("lu_unused", {24'd0, ctl}, {24'd0, C_RUN});
    // Match on RS1
    EX_RD = 5'd9; ID_RS1 = 5'd9; ID_USES_RS1 = 1'b1; settle();
    check("lu_rs1", {24'd0, ctl}, {24'd0, C_LDUSE});
    next_cycle(); idle(); settle();
    exp_stall = 32'd2;
    check("lu_rs1_stall", STALL_CYCLES, exp_stall);

    // Branch overrides a simultaneous load-use
    EX_BRANCH_TAKEN = 1'b1; EX_MEM_READ = 1'b1; EX_RD = 5'd7; ID_RS1 = 5'd7; ID_USES_RS1 = 1'b1; settle();
    check("br_over_lu", {24'd0, ctl}, {24'd0, C_BRANCH});
    next_cycle(); idle(); settle();
    check("br_stall", STALL_CYCLES, exp_stall);

    // MDU_DONE in RUN is ignored
    MDU_DONE = 1'b1; settle();
    check("done_in_run", {24'd0, ctl}, {24'd0, C_RUN});

    // MDU with 33 busy cycles then done
    start_cnt = 0;
    mdu_issue_and_hold(33, "mdu33");
    next_cycle(); idle(); MDU_DONE = 1'b1; settle();
    check("mdu33_done", {24'd0, ctl}, {24'd0, C_RUN});
    next_cycle(); idle(); settle();
    exp_stall = exp_stall + 32'd34;
    check("mdu33_run", {24'd0, ctl}, {24'd0, C_RUN});
    check("mdu33_stall", STALL_CYCLES, exp_stall);
    check("mdu33_starts", start_cnt, 32'd1);

    // Done arriving on the 40th busy cycle still releases
    mdu_issue_and_hold(39, "mdu40");
    next_cycle(); idle(); MDU_DONE = 1'b1; settle();
    check("mdu40_done", {24'd0, ctl}, {24'd0, C_RUN});
    next_cycle(); idle(); settle();
    exp_stall = exp_stall + 32'd40;
    check("mdu40_no_timeout", {24'd0, ctl}, {24'd0, C_RUN});
    check("mdu40_stall", STALL_CYCLES, exp_stall);

    // Timeout: 40 busy cycles with no done
    mdu_issue_and_hold(40, "mdu_to");
    next_cycle(); idle(); settle();
    exp_stall = exp_stall + 32'd41;
    check("to_error", {24'd0, ctl}, {24'd0, C_ERROR});
    check("to_stall", STALL_CYCLES, exp_stall);
    next_cycle(); idle(); MDU_DONE = 1'b1; settle();
    check("to_done_ignored", {24'd0, ctl}, {24'd0, C_ERROR});
    next_cycle(); idle(); settle();
    check("to_sticky", {24'd0, ctl}, {24'd0, C_ERROR});

    // Reset out of ERROR
    RST = 1'b1; settle();
    check("to_rst_ctl", {24'd0, ctl}, {24'd0, C_RUN});
    check("to_rst_stall", STALL_CYCLES, 32'd0);
    next_cycle(); idle(); RST = 1'b0; settle();

    // Reset after 10 busy cycles, then a fresh MDU op issues again
    start_cnt = 0;
    mdu_issue_and_hold(10, "mdu_rst");
    RST = 1'b1; settle();
    check("mid_rst_ctl", {24'd0, ctl}, {24'd0, C_RUN});
    check("mid_rst_stall", STALL_CYCLES, 32'd0);
    next_cycle(); idle(); RST = 1'b0; settle();
    check("post_rst_run", {24'd0, ctl}, {24'd0, C_RUN});
    next_cycle(); idle(); EX_IS_MDU = 1'b1; settle();
    check("post_rst_issue", {24'd0, ctl}, {24'd0, C_ISSUE});
    next_cycle(); idle(); settle();
    check("post_rst_hold", {24'd0, ctl}, {24'd0, C_HOLD});
    check("post_rst_starts", start_cnt, 32'd2);
    check("post_rst_stall", STALL_CYCLES, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
